// File: rtl/ac_motor_pkg.sv
// Shared types and default constants for the AC motor gate-drive stage.
// Holds the per-phase state encoding and the default dead-time configuration.
package ac_motor_pkg;

  localparam int DEAD_CYCLES_DEFAULT = 50;
  localparam int CNT_W_DEFAULT       = 12;

  typedef enum logic [1:0] {
    PH_OFF,
    PH_DEAD,
    PH_HIGH,
    PH_LOW
  } phase_state_e;

endpackage

// File: rtl/ac_motor_dead_time_phase.sv
// One phase leg: OFF/DEAD/HIGH/LOW state machine with its dead-time counter.
// Gate outputs are registered alongside the state, so no input reaches them combinationally.
module ac_motor_dead_time_phase
  import ac_motor_pkg::*;
#(
  parameter int DEAD_CYCLES = DEAD_CYCLES_DEFAULT,
  parameter int CNT_W       = CNT_W_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  input  logic cmd,
  input  logic run,
  output logic gate_h,
  output logic gate_l,
  output logic in_dead
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEAD_CYCLES - 1);

  phase_state_e           state;
  logic [CNT_W-1:0]       cnt;

  // NOTE: all state and output registers use non-blocking assignments so every
  // flop samples pre-edge values; blocking here would create order-dependent logic.
  always_ff @(posedge clk) begin
    if (rst || !run) begin
      // Shutdown is immediate: no dead time is needed to turn both gates off.
      state   <= PH_OFF;
      cnt     <= '0;
      gate_h  <= 1'b0;
      gate_l  <= 1'b0;
      in_dead <= 1'b0;
    end else begin
      case (state)
        PH_OFF: begin
          state   <= PH_DEAD;
          cnt     <= '0;
          in_dead <= 1'b1;
        end
        PH_DEAD: begin
          if (cnt == CNT_LAST) begin
            // Only the command present at exit decides which gate conducts.
            state   <= cmd ? PH_HIGH : PH_LOW;
            cnt     <= '0;
            gate_h  <= cmd;
            gate_l  <= ~cmd;
            in_dead <= 1'b0;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        PH_HIGH: begin
          if (!cmd) begin
            state   <= PH_DEAD;
            cnt     <= '0;
            gate_h  <= 1'b0;
            in_dead <= 1'b1;
          end
        end
        PH_LOW: begin
          if (cmd) begin
            state   <= PH_DEAD;
            cnt     <= '0;
            gate_l  <= 1'b0;
            in_dead <= 1'b1;
          end
        end
        default: begin
          state   <= PH_OFF;
          cnt     <= '0;
          gate_h  <= 1'b0;
          gate_l  <= 1'b0;
          in_dead <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/ac_motor_dead_time.sv
// Three-phase gate driver with dead-time insertion, bridge enable and sticky fault latch.
// A fault blocks all phases from the same edge it is seen until the next reset.
module ac_motor_dead_time
  import ac_motor_pkg::*;
#(
  parameter int DEAD_CYCLES = DEAD_CYCLES_DEFAULT,
  parameter int CNT_W       = CNT_W_DEFAULT
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       fault,
  input  logic       s1,
  input  logic       s2,
  input  logic       s3,
  output logic [2:0] gate_h,
  output logic [2:0] gate_l,
  output logic [2:0] in_dead,
  output logic       fault_latched
);

  logic [2:0] cmd;
  logic       run;

  assign cmd = {s3, s2, s1};
  // The raw fault is included so shutdown happens on the same edge the fault is seen.
  assign run = en & ~fault & ~fault_latched;

  always_ff @(posedge clk) begin
    if (rst) begin
      fault_latched <= 1'b0;
    end else if (fault) begin
      fault_latched <= 1'b1;
    end
  end

  for (genvar i = 0; i < 3; i++) begin : g_phase
    ac_motor_dead_time_phase #(
      .DEAD_CYCLES(DEAD_CYCLES),
      .CNT_W      (CNT_W)
    ) u_phase (
      .clk    (clk),
      .rst    (rst),
      .cmd    (cmd[i]),
      .run    (run),
      .gate_h (gate_h[i]),
      .gate_l (gate_l[i]),
      .in_dead(in_dead[i])
    );
  end

endmodule

// File: tb/tb_ac_motor_dead_time.sv
// Self-checking bench: randomized and directed stimulus against a countdown-based
// behavioural model of the dead-time gate driver, compared every cycle.
module tb_ac_motor_dead_time;

  localparam int D = 50;

  logic       clk;
  logic       rst;
  logic       en;
  logic       fault;
  logic [2:0] s;
  logic [2:0] gate_h;
  logic [2:0] gate_l;
  logic [2:0] in_dead;
  logic       fault_latched;

  int n_cmp  = 0;
  int n_fail = 0;
  bit cmp_en = 1'b0;

  ac_motor_dead_time #(.DEAD_CYCLES(D), .CNT_W(12)) dut (
    .clk          (clk),
    .rst          (rst),
    .en           (en),
    .fault        (fault),
    .s1           (s[0]),
    .s2           (s[1]),
    .s3           (s[2]),
    .gate_h       (gate_h),
    .gate_l       (gate_l),
    .in_dead      (in_dead),
    .fault_latched(fault_latched)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: each phase is either inactive, or active with a remaining dead-time
  // countdown; once the countdown is spent it conducts on the side held in cond.
  bit   m_active [3];
  int   m_left   [3];
  bit   m_cond   [3];
  bit   m_flt;
  logic [2:0] m_gh, m_gl, m_id;

  always @(posedge clk) begin
    if (rst) begin
      m_flt = 1'b0;
      for (int i = 0; i < 3; i++) begin
        m_active[i] = 1'b0;
        m_left[i]   = 0;
      end
    end else begin
      bit run;
      run = en && !fault && !m_flt;
      if (fault) m_flt = 1'b1;
      for (int i = 0; i < 3; i++) begin
        if (!run) begin
          m_active[i] = 1'b0;
        end else if (!m_active[i]) begin
          m_active[i] = 1'b1;
          m_left[i]   = D;
        end else if (m_left[i] > 0) begin
          m_left[i] = m_left[i] - 1;
          if (m_left[i] == 0) m_cond[i] = s[i];
        end else if (s[i] != m_cond[i]) begin
          m_left[i] = D;
        end
      end
    end
    for (int i = 0; i < 3; i++) begin
      m_gh[i] = m_active[i] && m_left[i] == 0 && m_cond[i];
      m_gl[i] = m_active[i] && m_left[i] == 0 && !m_cond[i];
      m_id[i] = m_active[i] && m_left[i] > 0;
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      check("gate_h", gate_h, m_gh);
      check("gate_l", gate_l, m_gl);
      check("in_dead", in_dead, m_id);
      check("fault_latched", fault_latched, m_flt);
      check("shoot_through", gate_h & gate_l, 3'b000);
    end
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Re-enable from OFF: dead for exactly D edges, then a gate on every phase.
  task automatic check_full_dead(input string tag);
    en = 1'b1;
    step(1);
    check({tag, "_dead_start"}, in_dead, 3'b111);
    step(D - 1);
    check({tag, "_still_off"}, gate_h | gate_l, 3'b000);
    check({tag, "_still_dead"}, in_dead, 3'b111);
    step(1);
    check({tag, "_gates_on"}, gate_h | gate_l, 3'b111);
    check({tag, "_dead_end"}, in_dead, 3'b000);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int off_cnt;
    logic [2:0] any_on;

    rst = 1'b1;
    en = 1'b0;
    fault = 1'b0;
    s = 3'b000;

    // Reset with random inputs applied.
    repeat (3) begin
      s = 3'($urandom);
      en = 1'($urandom);
      fault = 1'($urandom);
      @(negedge clk);
      cmp_en = 1'b1;
    end
    check("rst_gate_h", gate_h, 3'b000);
    check("rst_gate_l", gate_l, 3'b000);
    check("rst_in_dead", in_dead, 3'b000);
    check("rst_fault_latched", fault_latched, 1'b0);
    check("model_rst_id", m_id, 3'b000);

    rst = 1'b0;
    en = 1'b0;
    fault = 1'b0;
    s = 3'b000;
    step(2);

    // Enable with all commands low.
    en = 1'b1;
    step(1);
    check("en_dead", in_dead, 3'b111);
    step(D - 1);
    check("en_dead_last", in_dead, 3'b111);
    check("en_gl_before", gate_l, 3'b000);
    check("model_en_gl_before", m_gl, 3'b000);
    step(1);
    check("en_gl_on", gate_l, 3'b111);
    check("en_gh_off", gate_h, 3'b000);
    check("model_en_gl_on", m_gl, 3'b111);

    // Phase 1 LOW -> HIGH.
    s[0] = 1'b1;
    step(1);
    check("sw_gl_drop", gate_l, 3'b110);
    check("sw_dead", in_dead, 3'b001);
    step(D - 1);
    check("sw_gh_before", gate_h, 3'b000);
    step(1);
    check("sw_gh_on", gate_h, 3'b001);
    check("sw_gl_others", gate_l, 3'b110);
    check("model_sw_gh_on", m_gh, 3'b001);

    // Phase 1 HIGH with a 10-cycle low pulse: one full dead interval, back to HIGH.
    off_cnt = 0;
    s[0] = 1'b0;
    for (int c = 0; c < 200; c++) begin
      if (c == 10) s[0] = 1'b1;
      step(1);
      if (gate_h[0] || gate_l[0]) break;
      off_cnt++;
    end
    check("pulse_off_cycles", off_cnt, D);
    check("pulse_gh_back", gate_h[0], 1'b1);

    // Randomized command toggling with occasional enable drops.
    for (int c = 0; c < 1500; c++) begin
      if ($urandom_range(0, 59) == 0) begin
        int idx;
        idx = $urandom_range(0, 2);
        s[idx] = ~s[idx];
      end
      en = ($urandom_range(0, 299) != 0);
      step(1);
    end

    // Enable dropped mid-DEAD at cnt = 30, re-raised 5 cycles later.
    en = 1'b1;
    step(D + 5);
    en = 1'b0;
    step(1);
    check("endrop_all_off", gate_h | gate_l | in_dead, 3'b000);
    en = 1'b1;
    step(31);
    check("endrop_mid_dead", in_dead, 3'b111);
    en = 1'b0;
    step(1);
    check("endrop_dead_cleared", in_dead, 3'b000);
    step(4);
    check_full_dead("reen");

    // One-cycle fault pulse while running.
    fault = 1'b1;
    step(1);
    fault = 1'b0;
    check("flt_gates_off", gate_h | gate_l, 3'b000);
    check("flt_latched", fault_latched, 1'b1);
    any_on = 3'b000;
    for (int c = 0; c < 200; c++) begin
      if ($urandom_range(0, 4) == 0) s = 3'($urandom);
      step(1);
      any_on = any_on | gate_h | gate_l | in_dead;
    end
    check("flt_held_off", any_on, 3'b000);
    check("flt_still_latched", fault_latched, 1'b1);

    en = 1'b0;
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    check("flt_rst_cleared", fault_latched, 1'b0);
    check_full_dead("post_rst");
    step(5);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/ac_motor_dead_time.md
# ac_motor_dead_time

Gate-drive stage directly downstream of the switch-control block in the AC motor vector chain. It takes the three per-phase switch commands (s1, s2, s3; 1 = upper switch on) and produces complementary high-side and low-side gate signals. Every on-to-on transition gets a programmable dead time in which both gates are off. It also applies an enable, plus a sticky fault shutdown that is cleared only by reset.

## Interface
- DEAD_CYCLES, default 50: dead time in clk cycles (50 cycles = 1 µs at 20 ns clk). Legal range 1..4095.
- CNT_W, default 12: dead-time counter width. Requires DEAD_CYCLES ≤ 2**CNT_W − 1.
- clk  input  1  system clock; all logic on its rising edge
- rst  input  1  synchronous, active-high reset
- en  input  1  bridge enable; 0 = all gates off
- fault  input  1  external fault (overcurrent etc.), sampled each edge
- s1, s2, s3  input  1 each  phase switch commands from switch control
- gate_h  output  3  high-side gates; bit i = phase i+1
- gate_l  output  3  low-side gates; bit i = phase i+1
- in_dead  output  3  bit i = 1 while phase i+1 is in its DEAD state
- fault_latched  output  1  sticky fault flag

## Operation
- There is one independent FSM per phase, with states OFF, DEAD, HIGH and LOW. Each phase has its own counter cnt[CNT_W-1:0].
- OFF: gate_h = gate_l = 0.
  - Goes to DEAD with cnt = 0 when en = 1 and fault_latched = 0 and fault = 0.
- DEAD: both gates 0, in_dead = 1.
  - cnt increments each edge.
  - At the edge where cnt == DEAD_CYCLES−1, goes to HIGH if the command is 1, otherwise LOW.
  - Command changes during DEAD neither restart nor shorten the count. Only the command value at exit matters.
- HIGH: gate_h = 1. A command of 0 sends the phase to DEAD with cnt = 0.
- LOW: gate_l = 1. A command of 1 sends the phase to DEAD with cnt = 0.
- en = 0 in any state sends the phase to OFF on the next edge. This is not latched.
- fault = 1 at any edge does three things:
  - sets fault_latched = 1;
  - sends all phases to OFF;
  - keeps them in OFF regardless of en or commands until rst.
- Priority at an edge: rst > fault (or fault_latched) > en = 0 > command-driven transitions.
- Invariant: gate_h[i] & gate_l[i] is never 1. Any HIGH↔LOW change passes through at least DEAD_CYCLES cycles with both gates off.

## Timing
- Reset values: gate_h = 0, gate_l = 0, in_dead = 0, fault_latched = 0. All FSMs are in OFF with cnt = 0.
- All outputs are registered and decoded from the state register. There is no combinational input-to-output path.
- Command change seen at edge N:
  - the conducting gate drops after edge N;
  - the opposite gate rises after edge N+DEAD_CYCLES;
  - both gates are off for exactly DEAD_CYCLES cycles.
- Enable seen at edge N: the first gate rises after edge N+DEAD_CYCLES.
- Fault or en = 0 seen at edge N: all affected gates are 0 after edge N. Shutdown takes effect in the same cycle with no dead-time delay.
- rst asserted mid-DEAD or mid-conduction: everything is OFF after that edge. After rst deasserts, a full DEAD_CYCLES interval is required before any gate turns on.
- DEAD_CYCLES = 1: DEAD lasts exactly one cycle.

## Structure
- Shared package ac_motor_pkg holds:
  - the phase state enum (OFF, DEAD, HIGH, LOW);
  - the default DEAD_CYCLES and CNT_W constants.
- Sub-module ac_motor_dead_time_phase contains one FSM and its counter.
  - Inputs: clk, rst, cmd, run, where run = en & ~fault & ~fault_latched.
  - Outputs: gate_h, gate_l, in_dead.
  - The top instantiates it three times and owns the fault latch.

## Test plan
All scenarios use DEAD_CYCLES = 50. A checker asserts that gate_h[i] & gate_l[i] is never 1 throughout.
- Reset: hold rst for 3 cycles with random inputs → all outputs are 0 and fault_latched = 0.
- Enable with s = 000, en rising at edge N:
  - in_dead = 111 for 50 cycles;
  - gate_l = 111 after edge N+50;
  - gate_h stays 000.
- Steady LOW, s1 0→1 at edge N:
  - gate_l[0] = 0 after edge N;
  - gate_h[0] = 1 after edge N+50;
  - phases 2 and 3 are unchanged.
- Steady HIGH on phase 1, s1 1→0→1 with a 10-cycle low pulse:
  - both phase-1 gates are off for exactly 50 cycles;
  - gate_h[0] then returns to 1.
- One-cycle fault pulse while running:
  - all gates are 0 after that edge and fault_latched = 1;
  - all gates stay off for 200 cycles of command toggling with en = 1;
  - after rst, re-enabling needs the full 50 cycles again.
- en dropped at cnt = 30 in DEAD, then re-raised 5 cycles later → the phase waits the full 50 cycles from re-enable before any gate rises.
